// File: rtl/u_arrbam8_mac_acc.sv
// Approximate multiply-accumulate stage: 8x8 unsigned broken-array product
// (vertical cut V_CUT, horizontal cut H_CUT), summed over ACC_LEN beats.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holds valid and its data stable
// until the transfer. in_ready never depends on in_valid. out_valid/mac_out
// never depend on out_ready within a cycle.
module u_arrbam8_mac_acc #(
    parameter int V_CUT   = 10,
    parameter int H_CUT   = 0,
    parameter int ACC_LEN = 4,
    parameter int ACC_W   = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] mac_out
);

    localparam int CNT_W = $clog2(ACC_LEN + 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic             in_ready_q;
    logic             op_valid;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic             p_valid;
    logic [15:0]      p_reg;
    logic             accept;
    logic             last_beat;

    // Broken-array product: keep a[i]&b[j] only when i+j reaches the vertical
    // cut and row j is at or above the horizontal cut.
    function automatic logic [15:0] bam_product(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if ((i + j) >= V_CUT && j >= H_CUT && x[i] && y[j]) begin
                    s = s + (16'd1 << (i + j));
                end
            end
        end
        return s;
    endfunction

    // clear wins over everything, so a beat offered alongside it is refused.
    assign in_ready  = in_ready_q & ~clear;
    assign accept    = in_valid & in_ready;
    assign last_beat = (count == CNT_W'(ACC_LEN - 1));

    // Two-stage product pipe: operand register, then registered product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            p_valid  <= 1'b0;
            p_reg    <= '0;
        end else if (clear) begin
            op_valid <= 1'b0;
            p_valid  <= 1'b0;
        end else begin
            op_valid <= accept;
            if (accept) begin
                op_a <= a;
                op_b <= b;
            end
            p_valid <= op_valid;
            if (op_valid) begin
                p_reg <= bam_product(op_a, op_b);
            end
        end
    end

    // Group FSM: counts beats, accumulates products, publishes and holds the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            count      <= '0;
            acc        <= '0;
            mac_out    <= '0;
            out_valid  <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (clear) begin
            state      <= ACCUM;
            count      <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            if (p_valid) begin
                acc <= acc + ACC_W'(p_reg);
            end
            case (state)
                ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        count <= count + CNT_W'(1);
                        if (last_beat) begin
                            in_ready_q <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Pipe empty means the last product is already in acc.
                    if (!op_valid && !p_valid) begin
                        mac_out   <= acc;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        acc        <= '0;
                        count      <= '0;
                        in_ready_q <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule
